// File: rtl/gencon_defs.sv
// Shared calculator definitions: sequencer state encoding and operator codes.
package gencon_defs;

  typedef enum logic [1:0] {IDLE, EXEC_AS, MUL, DONE} seq_state_t;

  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

endpackage

// File: rtl/calc_addsub.sv
// Combinational (WIDTH+1)-bit adder; sub selects a + ~b + 1.
module calc_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  always_comb begin
    sum = a + (sub ? ~b : b) + {{WIDTH{1'b0}}, sub};
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator arithmetic sequencer: add/sub in one pass, radix-2 Booth multiply
// over WIDTH iterations, all through a single shared adder.
module calc_op_sequencer
  import gencon_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             op_error,
  output seq_state_t       seq_state
);

  localparam int CW = $clog2(WIDTH);

  seq_state_t       state, state_n;
  logic [2:0]       op_r, op_r_n;
  logic [WIDTH-1:0] a_r, a_r_n;
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] q, q_n;
  logic             q_m1, q_m1_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] result_n;
  logic             overflow_n, op_error_n;

  logic [WIDTH:0]   add_a, add_b, sum;
  logic             add_sub;
  logic             booth_add;
  logic [WIDTH:0]   acc_pre, acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   mul_top;

  calc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum)
  );

  // Adder input mux: Booth step by default, plain A±B during EXEC_AS.
  always_comb begin
    booth_add = q[0] ^ q_m1;
    add_a     = acc;
    add_b     = {a_r[WIDTH-1], a_r};
    add_sub   = q[0] & ~q_m1;
    if (state == EXEC_AS) begin
      add_a   = {a_r[WIDTH-1], a_r};
      add_b   = {q[WIDTH-1], q};
      add_sub = (op_r == OP_SUB);
    end
  end

  // Booth step: conditional add, then arithmetic shift of {acc, q, q_m1}.
  always_comb begin
    acc_pre = booth_add ? sum : acc;
    acc_sh  = {acc_pre[WIDTH], acc_pre[WIDTH:1]};
    q_sh    = {acc_pre[0], q[WIDTH-1:1]};
    mul_top = {acc_sh[WIDTH-1:0], q_sh[WIDTH-1]};
  end

  always_comb begin
    state_n    = state;
    op_r_n     = op_r;
    a_r_n      = a_r;
    acc_n      = acc;
    q_n        = q;
    q_m1_n     = q_m1;
    cnt_n      = cnt;
    result_n   = result;
    overflow_n = overflow;
    op_error_n = op_error;
    case (state)
      IDLE: begin
        if (start) begin
          op_r_n = op;
          a_r_n  = operand_a;
          q_n    = operand_b;
          q_m1_n = 1'b0;
          acc_n  = '0;
          cnt_n  = '0;
          case (op)
            OP_ADD, OP_SUB: state_n = EXEC_AS;
            OP_MUL:         state_n = MUL;
            default: begin
              state_n    = DONE;
              result_n   = '0;
              overflow_n = 1'b0;
              op_error_n = 1'b1;
            end
          endcase
        end
      end
      EXEC_AS: begin
        result_n   = sum[WIDTH-1:0];
        overflow_n = sum[WIDTH] ^ sum[WIDTH-1];
        op_error_n = 1'b0;
        state_n    = DONE;
      end
      MUL: begin
        acc_n  = acc_sh;
        q_n    = q_sh;
        q_m1_n = q[0];
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_n      = '0;
          result_n   = q_sh;
          overflow_n = ~((&mul_top) | ~(|mul_top));
          op_error_n = 1'b0;
          state_n    = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      op_r     <= '0;
      a_r      <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      overflow <= 1'b0;
      op_error <= 1'b0;
    end else begin
      state    <= state_n;
      op_r     <= op_r_n;
      a_r      <= a_r_n;
      acc      <= acc_n;
      q        <= q_n;
      q_m1     <= q_m1_n;
      cnt      <= cnt_n;
      result   <= result_n;
      overflow <= overflow_n;
      op_error <= op_error_n;
    end
  end

  always_comb begin
    busy      = (state == EXEC_AS) || (state == MUL);
    done      = (state == DONE);
    seq_state = state;
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: arithmetic reference model plus
// directed vectors with hand-computed results and latencies.
module tb_calc_op_sequencer;
  import gencon_defs::*;

  localparam int W = 16;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic         clk = 1'b0;
  logic         nRST = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, overflow, op_error;
  logic [W-1:0] result;
  seq_state_t   seq_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  calc_op_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .op_error  (op_error),
    .seq_state (seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact integer arithmetic; overflow means the true value leaves the signed W-bit range.
  function automatic void model_calc(input logic [2:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] r,
                                     output logic ov);
    longint ai = longint'($signed(a));
    longint bi = longint'($signed(b));
    longint full;
    case (o)
      3'b010:  full = ai + bi;
      3'b011:  full = ai - bi;
      default: full = ai * bi;
    endcase
    r  = full[W-1:0];
    ov = (full > MAXV) || (full < MINV);
  endfunction

  // Model: phase 0 idle, 1 computing (m_left cycles until done), 2 done pulse.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W-1:0] m_res   = '0;
  logic         m_ov    = 1'b0;
  logic         m_err   = 1'b0;
  logic [W-1:0] p_res, t_res;
  logic         p_ov, t_ov;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= '0;
      m_ov    <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          if (op == 3'b010 || op == 3'b011 || op == 3'b100) begin
            model_calc(op, operand_a, operand_b, t_res, t_ov);
            p_res   <= t_res;
            p_ov    <= t_ov;
            m_phase <= 1;
            m_left  <= (op == 3'b100) ? W : 1;
          end else begin
            m_phase <= 2;
            m_res   <= '0;
            m_ov    <= 1'b0;
            m_err   <= 1'b1;
          end
        end
        1: begin
          if (m_left == 1) begin
            m_phase <= 2;
            m_res   <= p_res;
            m_ov    <= p_ov;
            m_err   <= 1'b0;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (nRST && cmp_en) begin
      check("cyc_busy",     32'(busy),     32'(m_phase == 1));
      check("cyc_done",     32'(done),     32'(m_phase == 2));
      check("cyc_result",   32'(result),   32'(m_res));
      check("cyc_overflow", 32'(overflow), 32'(m_ov));
      check("cyc_op_error", 32'(op_error), 32'(m_err));
    end
  end

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] er, input logic eo,
                     input logic ee, input int elat, input bit inject);
    int lat = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        op = 3'b011;
        operand_a = 16'h5A5A;
        operand_b = 16'hA5A5;
      end
      if (inject && k == 5) begin
        start = 1'b1;
        op = 3'b010;
      end
      if (inject && k == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({name, "_latency"},  32'(lat),      32'(elat));
    check({name, "_busy"},     32'(busy_cnt), 32'(elat - 1));
    check({name, "_result"},   32'(result),   32'(er));
    check({name, "_overflow"}, 32'(overflow), 32'(eo));
    check({name, "_op_error"}, 32'(op_error), 32'(ee));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_result", 32'(result),    32'd0);
    check("rst_state",  32'(seq_state), 32'(IDLE));
    #2 nRST = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    run("add_2_3",       3'b010, 16'd2,    16'd3,    16'd5,    1'b0, 1'b0, 2,  1'b0);
    run("add_min_max",   3'b010, 16'h8000, 16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 2,  1'b0);
    run("add_max_1",     3'b010, 16'h7FFF, 16'd1,    16'h8000, 1'b1, 1'b0, 2,  1'b0);
    run("sub_3_5",       3'b011, 16'd3,    16'd5,    16'hFFFE, 1'b0, 1'b0, 2,  1'b0);
    run("sub_min_1",     3'b011, 16'h8000, 16'd1,    16'h7FFF, 1'b1, 1'b0, 2,  1'b0);
    run("mul_m3_m6",     3'b100, 16'hFFFD, 16'hFFFA, 16'd18,   1'b0, 1'b0, 17, 1'b1);
    run("mul_min_1",     3'b100, 16'h8000, 16'd1,    16'h8000, 1'b0, 1'b0, 17, 1'b1);
    run("mul_128_256",   3'b100, 16'd128,  16'd256,  16'h8000, 1'b1, 1'b0, 17, 1'b0);
    run("mul_min_m1",    3'b100, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 17, 1'b0);
    run("mul_m7_5",      3'b100, 16'hFFF9, 16'd5,    16'hFFDD, 1'b0, 1'b0, 17, 1'b0);
    run("illegal_7",     3'b111, 16'd9,    16'd9,    16'd0,    1'b0, 1'b1, 1,  1'b0);
    run("add_after_ill", 3'b010, 16'd1,    16'd1,    16'd2,    1'b0, 1'b0, 2,  1'b0);
    run("mul_min_m1_b",  3'b100, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 17, 1'b0);

    // Abort a multiply part-way through with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    op = 3'b100;
    operand_a = 16'd100;
    operand_b = 16'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("abort_busy",     32'(busy),      32'd0);
    check("abort_done",     32'(done),      32'd0);
    check("abort_result",   32'(result),    32'd0);
    check("abort_overflow", 32'(overflow),  32'd0);
    check("abort_op_error", 32'(op_error),  32'd0);
    check("abort_state",    32'(seq_state), 32'(IDLE));
    @(negedge clk);
    #2 nRST = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);

    run("mul_4_3", 3'b100, 16'd4, 16'd3, 16'd12, 1'b0, 1'b0, 17, 1'b0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Sequences the calculator's arithmetic, sitting between the input controller (gencon) and the display path. It receives two signed operands and an operator code. It then time-shares a single registered-input adder/subtractor, using it once for add/sub and iteratively for radix-2 Booth multiplication. It returns a WIDTH-bit two's-complement result with a one-cycle done pulse plus overflow and illegal-op flags.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 4..16; the multiply takes WIDTH iterations.

Ports:
clk  in  1  system clock; all state updates on rising edge
nRST  in  1  reset, asynchronous, active-low
start  in  1  request strobe; sampled only in IDLE
op  in  3  operator: 3'b010 add, 3'b011 sub, 3'b100 mul; any other code is illegal
operand_a  in  WIDTH  signed left operand; latched on an accepted start
operand_b  in  WIDTH  signed right operand; latched on an accepted start
busy  out  1  high in EXEC_AS and MUL states
done  out  1  one-cycle pulse, high only in DONE state
result  out  WIDTH  signed result; held until the next DONE
overflow  out  1  result not representable in WIDTH bits; held with result
op_error  out  1  last request used an illegal op; held with result
seq_state  out  seq_state_t  current state, for bench observation

Behaviour:
- Reset (nRST low, asynchronous): state IDLE; busy, done, overflow and op_error are 0; result is 0; internal registers and iteration counter are 0. Reset asserted mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: on start=1 at edge N, latch op, A and B. Next state depends on op:
    - add/sub: EXEC_AS.
    - mul: MUL.
    - illegal: DONE, and at the same edge load result=0, overflow=0, op_error=1.
  - EXEC_AS: one cycle. Computes A±B through the shared adder, both operands sign-extended to WIDTH+1 bits.
    - At edge N+1: result = sum[WIDTH-1:0], overflow = sum[WIDTH] XOR sum[WIDTH-1], op_error=0; next state DONE.
  - MUL: radix-2 Booth. The accumulator is WIDTH+1 bits, so that -2^(WIDTH-1) as the multiplicand is handled. Q holds B, plus a q_-1 bit; counter runs 0..WIDTH-1.
    - Per cycle, by {Q[0],q_-1}:
      - 01: acc += A via the shared adder.
      - 10: acc -= A via the shared adder.
      - 00/11: no add.
    - Then arithmetic-shift {acc,Q,q_-1} right by one.
    - After the iteration with counter=WIDTH-1 (edge N+WIDTH), the full 2*WIDTH product is P.
    - result = P[WIDTH-1:0]; overflow=1 unless P[2*WIDTH-1:WIDTH-1] are all equal; op_error=0; next state DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency, with start sampled at edge N:
  - done visible in cycle N+1..N+2 for illegal op.
  - done visible in cycle N+2..N+3 for add/sub.
  - done visible in cycle N+WIDTH+1..N+WIDTH+2 for mul (N+17 for WIDTH=16).
- start while busy or in DONE is ignored; no queuing. Operand/op changes after acceptance have no effect.
- result, overflow and op_error change only at the edge that enters DONE, so they are stable whenever done=1 and stay stable afterwards.
- Subtract is implemented as A + ~B + 1, with carry-in driven by the sub control. There is exactly one adder instance in the design.

Decomposition:
- Shared package gencon_defs gains:
  - seq_state_t enum {IDLE, EXEC_AS, MUL, DONE};
  - op code constants OP_NEG=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_MUL=3'b100.
- Sub-module calc_addsub: a purely combinational (WIDTH+1)-bit adder with a sub control, instantiated once. Muxing of its inputs stays in calc_op_sequencer.

Test Plan:
- Add, 2 + 3 → result=5, overflow=0; done pulses once, 2 cycles after start; busy high exactly 1 cycle.
- Add boundary: -32768 + 32767 → -1, overflow=0. Then 32767 + 1 → 0x8000, overflow=1.
- Sub, 3 - 5 → -2. Then -32768 - 1 → 0x7FFF, overflow=1.
- Mul, (-3)*(-6) → 18; then -32768*1 → 0x8000, overflow=0; then 128*256 → 0x8000, overflow=1; -32768*-1 → overflow=1. Each done arrives 17 cycles after start, and start pulses mid-multiply are ignored.
- Illegal op 3'b111 → done after 1 cycle, op_error=1, result=0. A following legal add clears op_error.
- Assert nRST at iteration 8 of a multiply → all outputs 0 immediately, no done pulse. A new request after reset completes correctly (4*3 → 12).
